// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the push-button conditioning stage.
package button_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } btn_state_t;

   localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit flop-chain synchroniser for an asynchronous level input.
module sync_2ff
   import button_conditioner_pkg::*;
(
   input  logic clock_i,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces a raw push-button, emitting a one-cycle strobe per
// accepted press plus optional hold-to-repeat strobes.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned REPEAT_DELAY    = 0,
   parameter int unsigned REPEAT_PERIOD   = 1000,
   parameter int unsigned CNT_WIDTH       = 20
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic button_i,
   output logic pulse_o,
   output logic level_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] RD_LAST = (REPEAT_DELAY > 0) ? CNT_WIDTH'(REPEAT_DELAY - 1) : '0;
   localparam logic [CNT_WIDTH-1:0] RP_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);
   localparam logic                 REPEAT_EN = (REPEAT_DELAY != 0);

   if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_WIDTH)) begin : g_bad_debounce
      $error("button_conditioner: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
   end
   if (REPEAT_PERIOD < 2 || 64'(REPEAT_PERIOD) > (64'd1 << CNT_WIDTH)) begin : g_bad_period
      $error("button_conditioner: REPEAT_PERIOD must be >= 2 and fit CNT_WIDTH");
   end
   if (REPEAT_DELAY == 1 || 64'(REPEAT_DELAY) > (64'd1 << CNT_WIDTH)) begin : g_bad_delay
      $error("button_conditioner: REPEAT_DELAY must not be 1 and must fit CNT_WIDTH");
   end

   logic                 btn_s;
   btn_state_t           state_q, state_d;
   logic [CNT_WIDTH-1:0] db_cnt_q, db_cnt_d;
   logic [CNT_WIDTH-1:0] rpt_cnt_q, rpt_cnt_d;
   logic                 rpt_first_q, rpt_first_d;
   logic                 pulse_q, pulse_d;
   logic                 level_q, level_d;

   sync_2ff u_sync (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .d_i     (button_i),
      .q_o     (btn_s)
   );

   always_comb begin
      state_d     = state_q;
      db_cnt_d    = db_cnt_q;
      rpt_cnt_d   = rpt_cnt_q;
      rpt_first_d = rpt_first_q;
      level_d     = level_q;
      pulse_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d  = PRESS_WAIT;
               db_cnt_d = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_d = IDLE;
            end else if (db_cnt_q == DB_LAST) begin
               state_d     = HELD;
               level_d     = 1'b1;
               pulse_d     = 1'b1;
               rpt_cnt_d   = '0;
               rpt_first_d = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            // Release is checked first so a repeat landing on the same edge is dropped.
            if (!btn_s) begin
               state_d  = RELEASE_WAIT;
               db_cnt_d = '0;
            end else if (!REPEAT_EN) begin
               rpt_cnt_d = '0;
            end else if (( rpt_first_q && rpt_cnt_q == RD_LAST) ||
                         (!rpt_first_q && rpt_cnt_q == RP_LAST)) begin
               pulse_d     = 1'b1;
               rpt_cnt_d   = '0;
               rpt_first_d = 1'b0;
            end else begin
               rpt_cnt_d = rpt_cnt_q + CNT_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (btn_s) begin
               state_d     = HELD;
               rpt_cnt_d   = '0;
               rpt_first_d = 1'b1;
            end else if (db_cnt_q == DB_LAST) begin
               state_d = IDLE;
               level_d = 1'b0;
            end else begin
               db_cnt_d = db_cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         db_cnt_q    <= '0;
         rpt_cnt_q   <= '0;
         rpt_first_q <= 1'b0;
         pulse_q     <= 1'b0;
         level_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         db_cnt_q    <= db_cnt_d;
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_first_q <= rpt_first_d;
         pulse_q     <= pulse_d;
         level_q     <= level_d;
      end
   end

   assign pulse_o = pulse_q;
   assign level_o = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: one repeat-enabled and one repeat-disabled instance
// driven by the same button, checked against a run-length reference model.
module tb_button_conditioner;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic clock_i = 1'b0;
   logic reset_i;
   logic button_i;
   logic pulse_r, level_r, pulse_n, level_n;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic b1, b2, level, pulse;
      int   run, edge_n, t0;
   } mdl_t;

   mdl_t m_r, m_n;

   button_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .CNT_WIDTH       (8)
   ) dut_rep (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .button_i (button_i),
      .pulse_o  (pulse_r),
      .level_o  (level_r)
   );

   button_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (0),
      .REPEAT_PERIOD   (RP),
      .CNT_WIDTH       (8)
   ) dut_nr (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .button_i (button_i),
      .pulse_o  (pulse_n),
      .level_o  (level_n)
   );

   always #5 clock_i = ~clock_i;

   function automatic mdl_t model_reset();
      mdl_t m;
      m.b1 = 1'b0; m.b2 = 1'b0; m.level = 1'b0; m.pulse = 1'b0;
      m.run = 0; m.edge_n = 0; m.t0 = 0;
      return m;
   endfunction

   // Level flips once DB+1 consecutive synchronised samples disagree with it;
   // repeats fire at t0+rd, t0+rd+rp, ... where t0 is the start of the current hold.
   function automatic mdl_t model_step(mdl_t m, logic btn, int rd, int rp);
      logic s;
      int   el;
      s = m.b2;
      m.b2 = m.b1;
      m.b1 = btn;
      m.edge_n++;
      m.pulse = 1'b0;
      if (s !== m.level) begin
         m.run++;
         if (m.run == DB + 1) begin
            m.level = s;
            m.run = 0;
            if (s) begin
               m.pulse = 1'b1;
               m.t0 = m.edge_n;
            end
         end
      end else begin
         if (m.level && m.run > 0) begin
            m.t0 = m.edge_n;
         end else if (m.level && rd > 0) begin
            el = m.edge_n - m.t0;
            if (el >= rd && ((el - rd) % rp) == 0) m.pulse = 1'b1;
         end
         m.run = 0;
      end
      return m;
   endfunction

   always @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         m_r = model_reset();
         m_n = model_reset();
      end else begin
         m_r = model_step(m_r, button_i, RD, 0 + RP);
         m_n = model_step(m_n, button_i, 0, RP);
      end
   end

   task automatic cycle();
      @(posedge clock_i);
      #1;
   endtask

   task automatic settle(input int n);
      button_i = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic test_reset();
      reset_i  = 1'b1;
      button_i = 1'b1;
      repeat (4) cycle();
      checks++;
      if ({pulse_r, level_r, pulse_n, level_n} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_held: got %b expected 0000", {pulse_r, level_r, pulse_n, level_n});
      end
      button_i = 1'b0;
      repeat (2) cycle();
      #2 reset_i = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cycle();
         checks++;
         if ({pulse_r, level_r, pulse_n, level_n} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release k=%0d: got %b expected 0000", k, {pulse_r, level_r, pulse_n, level_n});
         end
      end
   endtask

   task automatic test_clean_press();
      int npulse = 0;
      button_i = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         cycle();
         checks++;
         if ({pulse_r, level_r, pulse_n, level_n} !== {m_r.pulse, m_r.level, m_n.pulse, m_n.level}) begin
            errors++;
            $display("FAIL clean_press_model k=%0d: got %b expected %b", k,
                     {pulse_r, level_r, pulse_n, level_n}, {m_r.pulse, m_r.level, m_n.pulse, m_n.level});
         end
         if (k <= 15) begin
            checks++;
            if ({pulse_r, level_r} !== {(k == 7), (k >= 7)}) begin
               errors++;
               $display("FAIL clean_press_rep k=%0d: got %b expected %b", k, {pulse_r, level_r}, {(k == 7), (k >= 7)});
            end
         end
         checks++;
         if ({pulse_n, level_n} !== {(k == 7), (k >= 7)}) begin
            errors++;
            $display("FAIL clean_press_nr k=%0d: got %b expected %b", k, {pulse_n, level_n}, {(k == 7), (k >= 7)});
         end
         npulse += int'(pulse_n);
      end
      checks++;
      if (npulse != 1) begin
         errors++;
         $display("FAIL clean_press_count: got %0d expected 1", npulse);
      end
      settle(12);
   endtask

   task automatic test_bounce();
      for (int k = 0; k < 18; k++) begin
         button_i = (k < 8) && ((k / 2) % 2 == 0);
         cycle();
         checks++;
         if ({pulse_r, level_r, pulse_n, level_n} !== 4'b0000) begin
            errors++;
            $display("FAIL bounce k=%0d: got %b expected 0000", k, {pulse_r, level_r, pulse_n, level_n});
         end
      end
   endtask

   task automatic test_release_glitch();
      button_i = 1'b1;
      for (int k = 1; k <= 9; k++) cycle();
      for (int k = 0; k < 12; k++) begin
         button_i = (k >= 2);
         cycle();
         checks++;
         if ({pulse_r, level_r, pulse_n, level_n} !== {m_r.pulse, m_r.level, m_n.pulse, m_n.level}) begin
            errors++;
            $display("FAIL glitch_model k=%0d: got %b expected %b", k,
                     {pulse_r, level_r, pulse_n, level_n}, {m_r.pulse, m_r.level, m_n.pulse, m_n.level});
         end
         checks++;
         if ({level_r, pulse_n, level_n} !== 3'b101) begin
            errors++;
            $display("FAIL glitch_hold k=%0d: got %b expected 101", k, {level_r, pulse_n, level_n});
         end
      end
      button_i = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         cycle();
         checks++;
         if ({level_r, pulse_n, level_n} !== {(k < 7), 1'b0, (k < 7)}) begin
            errors++;
            $display("FAIL glitch_release k=%0d: got %b expected %b", k, {level_r, pulse_n, level_n}, {(k < 7), 1'b0, (k < 7)});
         end
      end
      settle(4);
   endtask

   task automatic test_auto_repeat();
      int npulse = 0;
      button_i = 1'b1;
      for (int k = 1; k <= 37; k++) begin
         cycle();
         checks++;
         if (pulse_r !== (k inside {7, 17, 22, 27, 32, 37})) begin
            errors++;
            $display("FAIL repeat_pulse k=%0d: got %b expected %b", k, pulse_r, (k inside {7, 17, 22, 27, 32, 37}));
         end
         checks++;
         if ({pulse_r, level_r, pulse_n, level_n} !== {m_r.pulse, m_r.level, m_n.pulse, m_n.level}) begin
            errors++;
            $display("FAIL repeat_model k=%0d: got %b expected %b", k,
                     {pulse_r, level_r, pulse_n, level_n}, {m_r.pulse, m_r.level, m_n.pulse, m_n.level});
         end
         npulse += int'(pulse_r);
      end
      checks++;
      if (npulse != 6) begin
         errors++;
         $display("FAIL repeat_count: got %0d expected 6", npulse);
      end
      settle(12);
   endtask

   task automatic test_release_beats_repeat();
      button_i = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         cycle();
         checks++;
         if ({pulse_r, level_r} !== {(k == 7), (k >= 7 && k < 21)}) begin
            errors++;
            $display("FAIL release_vs_repeat k=%0d: got %b expected %b", k,
                     {pulse_r, level_r}, {(k == 7), (k >= 7 && k < 21)});
         end
         if (k == 14) button_i = 1'b0;
      end
      settle(4);
   endtask

   task automatic test_mid_reset();
      button_i = 1'b1;
      repeat (4) cycle();
      #2 reset_i = 1'b1;
      #1;
      checks++;
      if ({pulse_r, level_r, pulse_n, level_n} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_press_wait: got %b expected 0000", {pulse_r, level_r, pulse_n, level_n});
      end
      #2 reset_i = 1'b0;
      repeat (7) cycle();
      checks++;
      if ({pulse_r, level_r, pulse_n, level_n} !== 4'b1111) begin
         errors++;
         $display("FAIL reset_pre_pulse: got %b expected 1111", {pulse_r, level_r, pulse_n, level_n});
      end
      #2 reset_i = 1'b1;
      #1;
      checks++;
      if ({pulse_r, level_r, pulse_n, level_n} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_in_pulse: got %b expected 0000", {pulse_r, level_r, pulse_n, level_n});
      end
      #2 reset_i = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         cycle();
         checks++;
         if ({pulse_r, level_r, pulse_n, level_n} !== {(k == 7), (k >= 7), (k == 7), (k >= 7)}) begin
            errors++;
            $display("FAIL reset_redebounce k=%0d: got %b expected %b", k,
                     {pulse_r, level_r, pulse_n, level_n}, {(k == 7), (k >= 7), (k == 7), (k >= 7)});
         end
      end
      settle(12);
   endtask

   task automatic test_random();
      int len;
      for (int b = 0; b < 70; b++) begin
         button_i = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(15, 35)) : int'($urandom_range(1, 9));
         for (int i = 0; i < len; i++) begin
            cycle();
            checks++;
            if ({pulse_r, level_r, pulse_n, level_n} !== {m_r.pulse, m_r.level, m_n.pulse, m_n.level}) begin
               errors++;
               $display("FAIL random_model b=%0d i=%0d: got %b expected %b", b, i,
                        {pulse_r, level_r, pulse_n, level_n}, {m_r.pulse, m_r.level, m_n.pulse, m_n.level});
            end
         end
      end
      settle(12);
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_glitch();
      test_auto_repeat();
      test_release_beats_repeat();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
